// File: rtl/seg_display_scanner.sv
// -----------------------------------------------------------------------------
// seg_display_scanner
//   Scans NUM_DIGITS common-anode 7-segment digits through one shared external
//   BCD decoder. Each digit slot is REFRESH_DIV cycles: BLANK_CYCLES with all
//   anodes off (anti-ghosting), then the digit is shown. New values arrive via a
//   valid/ready shadow register and are committed only at frame boundaries (or
//   while idle), so a frame never mixes old and new digits.
//
// Ports
//   clk, reset_n   clock (rising edge), asynchronous active-low reset
//   enable         1 = scan, 0 = dark and held idle
//   lz_en          1 = suppress leading zeros (digit 0 always shown)
//   load_valid/load_ready/load_data  handshake for a new packed-BCD value
//   bcd_to_dec     nibble presented to the shared decoder
//   seg_from_dec   decoder result {a..g}, active-high
//   seg_out        registered segments {a..g}, active-high
//   an_n           registered anode enables, active-low, one-hot-low
//   frame_tick     one-cycle pulse after each completed frame
// -----------------------------------------------------------------------------
module seg_display_scanner #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    enable,
  input  logic                    lz_en,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [4*NUM_DIGITS-1:0] load_data,
  output logic [3:0]              bcd_to_dec,
  input  logic [6:0]              seg_from_dec,
  output logic [6:0]              seg_out,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic                    frame_tick
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [6:0]       SEG_DASH   = 7'b0000001;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_SHOW  = 2'd2
  } state_t;

  state_t                  state_r;
  logic [IDX_W-1:0]        idx_r;
  logic [CNT_W-1:0]        cnt_r;
  logic [4*NUM_DIGITS-1:0] active_r;
  logic [4*NUM_DIGITS-1:0] shadow_r;
  logic                    pending_r;
  logic [6:0]              seg_r;
  logic [NUM_DIGITS-1:0]   an_r;
  logic                    frame_tick_r;

  logic [3:0]              nib_s [NUM_DIGITS];
  logic [NUM_DIGITS-1:0]   lz_mask_s;
  logic [3:0]              bcd_s;
  logic [6:0]              show_seg_s;
  logic [NUM_DIGITS-1:0]   show_an_s;

  // Active-low one-hot anode pattern for the selected digit.
  function automatic logic [NUM_DIGITS-1:0] anode_sel(input logic [IDX_W-1:0] idx);
    logic [NUM_DIGITS-1:0] res;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      res[i] = (idx != IDX_W'(i));
    end
    return res;
  endfunction

  // Split the committed value into per-digit nibbles.
  always_comb begin
    for (int i = 0; i < NUM_DIGITS; i++) begin
      nib_s[i] = active_r[4*i +: 4];
    end
  end

  // Leading-zero mask: a digit is blank when it and all higher digits are zero.
  always_comb begin
    logic zero_run;
    lz_mask_s = '0;
    zero_run  = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run = zero_run & (nib_s[i] == 4'd0);
      if (i != 0) begin
        lz_mask_s[i] = lz_en & zero_run;
      end else begin
        lz_mask_s[i] = 1'b0;
      end
    end
  end

  // Decoder input follows the current digit throughout BLANK so it settles before SHOW.
  always_comb begin
    bcd_s = nib_s[idx_r];
  end

  // Segment/anode values to be loaded on the edge entering SHOW.
  always_comb begin
    show_seg_s = 7'd0;
    show_an_s  = '1;
    if (lz_mask_s[idx_r]) begin
      show_seg_s = 7'd0;
      show_an_s  = '1;
    end else if (bcd_s > 4'd9) begin
      show_seg_s = SEG_DASH;
      show_an_s  = anode_sel(idx_r);
    end else begin
      show_seg_s = seg_from_dec;
      show_an_s  = anode_sel(idx_r);
    end
  end

  // Scan sequencer, load handshake and registered display outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= ST_IDLE;
      idx_r        <= '0;
      cnt_r        <= '0;
      active_r     <= '0;
      shadow_r     <= '0;
      pending_r    <= 1'b0;
      seg_r        <= 7'd0;
      an_r         <= '1;
      frame_tick_r <= 1'b0;
    end else begin
      frame_tick_r <= 1'b0;

      // Accept and commit are exclusive: commit needs pending_r=1, accept needs 0.
      if (load_valid && !pending_r) begin
        shadow_r  <= load_data;
        pending_r <= 1'b1;
      end

      if (!enable && (state_r != ST_IDLE)) begin
        // Truncated frame: go dark immediately, no frame_tick.
        state_r <= ST_IDLE;
        idx_r   <= '0;
        cnt_r   <= '0;
        seg_r   <= 7'd0;
        an_r    <= '1;
      end else begin
        case (state_r)
          ST_IDLE: begin
            seg_r <= 7'd0;
            an_r  <= '1;
            if (pending_r) begin
              active_r  <= shadow_r;
              pending_r <= 1'b0;
            end
            if (enable) begin
              state_r <= ST_BLANK;
              idx_r   <= '0;
              cnt_r   <= '0;
            end
          end
          ST_BLANK: begin
            cnt_r <= cnt_r + CNT_W'(1);
            if (cnt_r == BLANK_LAST) begin
              state_r <= ST_SHOW;
              seg_r   <= show_seg_s;
              an_r    <= show_an_s;
            end
          end
          ST_SHOW: begin
            if (cnt_r == SLOT_LAST) begin
              state_r <= ST_BLANK;
              cnt_r   <= '0;
              seg_r   <= 7'd0;
              an_r    <= '1;
              if (idx_r == IDX_LAST) begin
                idx_r        <= '0;
                frame_tick_r <= 1'b1;
                if (pending_r) begin
                  active_r  <= shadow_r;
                  pending_r <= 1'b0;
                end
              end else begin
                idx_r <= idx_r + IDX_W'(1);
              end
            end else begin
              cnt_r <= cnt_r + CNT_W'(1);
            end
          end
          default: begin
            state_r <= ST_IDLE;
            idx_r   <= '0;
            cnt_r   <= '0;
            seg_r   <= 7'd0;
            an_r    <= '1;
          end
        endcase
      end
    end
  end

  assign load_ready = ~pending_r;
  assign bcd_to_dec = bcd_s;
  assign seg_out    = seg_r;
  assign an_n       = an_r;
  assign frame_tick = frame_tick_r;

endmodule

// File: tb/tb_seg_display_scanner.sv
// -----------------------------------------------------------------------------
// tb_seg_display_scanner
//   Directed bench for seg_display_scanner with NUM_DIGITS=4, REFRESH_DIV=8,
//   BLANK_CYCLES=2 and an ideal BCD decoder. Outputs are sampled 1 time unit
//   after each rising edge.
// -----------------------------------------------------------------------------
module tb_seg_display_scanner;

  localparam int ND = 4;

  logic          clk;
  logic          reset_n;
  logic          enable;
  logic          lz_en;
  logic          load_valid;
  logic          load_ready;
  logic [15:0]   load_data;
  logic [3:0]    bcd_to_dec;
  logic [6:0]    seg_from_dec;
  logic [6:0]    seg_out;
  logic [ND-1:0] an_n;
  logic          frame_tick;

  int checks;
  int errors;

  // Segment patterns {a..g}
  localparam logic [6:0] S0 = 7'b1111110;
  localparam logic [6:0] S1 = 7'b0110000;
  localparam logic [6:0] S2 = 7'b1101101;
  localparam logic [6:0] S3 = 7'b1111001;
  localparam logic [6:0] S4 = 7'b0110011;
  localparam logic [6:0] S5 = 7'b1011011;
  localparam logic [6:0] SD = 7'b0000001;
  localparam logic [6:0] SX = 7'b0000000;

  seg_display_scanner #(
    .NUM_DIGITS  (ND),
    .REFRESH_DIV (8),
    .BLANK_CYCLES(2)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .enable      (enable),
    .lz_en       (lz_en),
    .load_valid  (load_valid),
    .load_ready  (load_ready),
    .load_data   (load_data),
    .bcd_to_dec  (bcd_to_dec),
    .seg_from_dec(seg_from_dec),
    .seg_out     (seg_out),
    .an_n        (an_n),
    .frame_tick  (frame_tick)
  );

  // Ideal shared decoder.
  function automatic logic [6:0] dec7(input logic [3:0] b);
    case (b)
      4'd0:    dec7 = 7'b1111110;
      4'd1:    dec7 = 7'b0110000;
      4'd2:    dec7 = 7'b1101101;
      4'd3:    dec7 = 7'b1111001;
      4'd4:    dec7 = 7'b0110011;
      4'd5:    dec7 = 7'b1011011;
      4'd6:    dec7 = 7'b1011111;
      4'd7:    dec7 = 7'b1110000;
      4'd8:    dec7 = 7'b1111111;
      4'd9:    dec7 = 7'b1111011;
      default: dec7 = 7'b0000000;
    endcase
  endfunction

  assign seg_from_dec = dec7(bcd_to_dec);

  // 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One 8-cycle digit slot, starting just after the edge that entered BLANK.
  // A load presented before the call is held for exactly one edge.
  task automatic slot(input string tag, input logic [3:0] e_an, input logic [6:0] e_seg,
                      input logic e_ft);
    check({tag, "_blank0_an"}, 32'(an_n), 32'hF);
    check({tag, "_blank0_seg"}, 32'(seg_out), 32'h0);
    tick();
    load_valid = 1'b0;
    check({tag, "_blank1_an"}, 32'(an_n), 32'hF);
    check({tag, "_blank1_seg"}, 32'(seg_out), 32'h0);
    tick();
    check({tag, "_show_an"}, 32'(an_n), 32'(e_an));
    check({tag, "_show_seg"}, 32'(seg_out), 32'(e_seg));
    check({tag, "_show_ft"}, 32'(frame_tick), 32'h0);
    repeat (5) tick();
    check({tag, "_hold_an"}, 32'(an_n), 32'(e_an));
    check({tag, "_hold_seg"}, 32'(seg_out), 32'(e_seg));
    tick();
    check({tag, "_ft"}, 32'(frame_tick), 32'(e_ft));
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    reset_n    = 1'b0;
    enable     = 1'b0;
    lz_en      = 1'b0;
    load_valid = 1'b0;
    load_data  = 16'h0000;

    #12;
    check("rst_seg", 32'(seg_out), 32'h0);
    check("rst_an", 32'(an_n), 32'hF);
    check("rst_ft", 32'(frame_tick), 32'h0);
    check("rst_ready", 32'(load_ready), 32'h1);
    check("rst_bcd", 32'(bcd_to_dec), 32'h0);

    // 1: load while disabled, commit in IDLE, then one full frame.
    reset_n    = 1'b1;
    load_valid = 1'b1;
    load_data  = 16'h1234;
    tick();
    check("t1_ready_low", 32'(load_ready), 32'h0);
    load_valid = 1'b0;
    tick();
    check("t1_ready_commit", 32'(load_ready), 32'h1);
    check("t1_idle_an", 32'(an_n), 32'hF);
    enable = 1'b1;
    tick();
    slot("t1_d0", 4'b1110, S4, 1'b0);
    slot("t1_d1", 4'b1101, S3, 1'b0);
    slot("t1_d2", 4'b1011, S2, 1'b0);
    slot("t1_d3", 4'b0111, S1, 1'b1);

    // 2: leading-zero suppression; load 0050 during a 1234 frame.
    lz_en      = 1'b1;
    load_valid = 1'b1;
    load_data  = 16'h0050;
    slot("t2a_d0", 4'b1110, S4, 1'b0);
    check("t2a_ready_pending", 32'(load_ready), 32'h0);
    slot("t2a_d1", 4'b1101, S3, 1'b0);
    slot("t2a_d2", 4'b1011, S2, 1'b0);
    slot("t2a_d3", 4'b0111, S1, 1'b1);
    check("t2a_ready_after", 32'(load_ready), 32'h1);
    load_valid = 1'b1;
    load_data  = 16'h0000;
    slot("t2b_d0", 4'b1110, S0, 1'b0);
    slot("t2b_d1", 4'b1101, S5, 1'b0);
    slot("t2b_d2", 4'b1111, SX, 1'b0);
    slot("t2b_d3", 4'b1111, SX, 1'b1);
    slot("t2c_d0", 4'b1110, S0, 1'b0);

    // 3: mid-frame load of 1111, second load during pending ignored.
    load_valid = 1'b1;
    load_data  = 16'h1111;
    slot("t3_d1", 4'b1111, SX, 1'b0);
    check("t3_ready_pending", 32'(load_ready), 32'h0);
    load_valid = 1'b1;
    load_data  = 16'h9999;
    slot("t3_d2", 4'b1111, SX, 1'b0);
    check("t3_ready_still", 32'(load_ready), 32'h0);
    slot("t3_d3", 4'b1111, SX, 1'b1);
    check("t3_ready_frame", 32'(load_ready), 32'h1);

    // 4: new frame shows 1111; queue 1C23 for the next frame.
    load_valid = 1'b1;
    load_data  = 16'h1C23;
    slot("t4a_d0", 4'b1110, S1, 1'b0);
    slot("t4a_d1", 4'b1101, S1, 1'b0);
    slot("t4a_d2", 4'b1011, S1, 1'b0);
    slot("t4a_d3", 4'b0111, S1, 1'b1);
    lz_en = 1'b0;
    slot("t4b_d0", 4'b1110, S3, 1'b0);
    slot("t4b_d1", 4'b1101, S2, 1'b0);
    slot("t4b_d2", 4'b1011, SD, 1'b0);
    slot("t4b_d3", 4'b0111, S1, 1'b1);

    // 5: drop enable mid-SHOW of digit 2, then re-enable.
    slot("t5_d0", 4'b1110, S3, 1'b0);
    slot("t5_d1", 4'b1101, S2, 1'b0);
    tick();
    tick();
    check("t5_d2_an", 32'(an_n), 32'b1011);
    check("t5_d2_seg", 32'(seg_out), 32'(SD));
    tick();
    tick();
    enable = 1'b0;
    tick();
    check("t5_off_an", 32'(an_n), 32'hF);
    check("t5_off_seg", 32'(seg_out), 32'h0);
    check("t5_off_ft", 32'(frame_tick), 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t5_idle_ft", 32'(frame_tick), 32'h0);
      check("t5_idle_an", 32'(an_n), 32'hF);
    end
    enable = 1'b1;
    tick();
    slot("t5_re_d0", 4'b1110, S3, 1'b0);

    // 6: async reset between edges while a load is pending.
    tick();
    tick();
    check("t6_show_an", 32'(an_n), 32'b1101);
    load_valid = 1'b1;
    load_data  = 16'h4321;
    tick();
    load_valid = 1'b0;
    check("t6_ready_pending", 32'(load_ready), 32'h0);
    #2;
    reset_n = 1'b0;
    #1;
    check("t6_rst_an", 32'(an_n), 32'hF);
    check("t6_rst_seg", 32'(seg_out), 32'h0);
    check("t6_rst_ft", 32'(frame_tick), 32'h0);
    check("t6_rst_ready", 32'(load_ready), 32'h1);
    check("t6_rst_bcd", 32'(bcd_to_dec), 32'h0);
    reset_n = 1'b1;
    tick();
    slot("t6_re_d0", 4'b1110, S0, 1'b0);
    slot("t6_re_d1", 4'b1101, S0, 1'b0);
    check("t6_ready_final", 32'(load_ready), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
